// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO input interrupt controller:
// register addresses, the per-pin detection type and the register-select type.
package gpio_irq_pkg;

    typedef logic [2:0] reg_sel_t;

    localparam reg_sel_t ADDR_IN     = 3'd0;
    localparam reg_sel_t ADDR_IE     = 3'd1;
    localparam reg_sel_t ADDR_TYPE   = 3'd2;
    localparam reg_sel_t ADDR_POL    = 3'd3;
    localparam reg_sel_t ADDR_BOTH   = 3'd4;
    localparam reg_sel_t ADDR_STATUS = 3'd5;

    typedef enum logic {
        TYPE_LEVEL = 1'b0,
        TYPE_EDGE  = 1'b1
    } irq_type_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs; also used by the GPIO
// port input path. Every stage clears on a synchronous active-low reset.
module gpio_sync
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff_p [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                ff_p[i] <= '0;
            end
        end else begin
            ff_p[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff_p[i] <= ff_p[i-1];
            end
        end
    end

    assign q = ff_p[STAGES-1];

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input interrupt controller: synchronises pads, detects level/edge
// events per pin, latches them into W1C STATUS and drives a single irq_o.
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [2:0]       addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             ack_o,
    output logic             irq_o
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CNT_W     = $clog2(PRIME_MAX + 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] prev_p1;
    logic [CNT_W-1:0] prime_cnt;
    logic             primed;

    logic [WIDTH-1:0] ie_q;
    logic [WIDTH-1:0] type_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] both_q;
    logic [WIDTH-1:0] status_q;

    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] rdata_q;
    logic             ack_q;

    reg_sel_t sel;
    logic     wr_en;
    logic     rd_en;

    function automatic logic edge_hit(input logic cur, input logic prev,
                                      input logic pol, input logic both);
        logic rise;
        logic fall;
        rise = cur & ~prev;
        fall = ~cur & prev;
        return both ? (rise | fall) : (pol ? rise : fall);
    endfunction

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_i),
        .q     (sync_p0)
    );

    assign sel    = addr_i;
    assign wr_en  = req_i & we_i;
    assign rd_en  = req_i & ~we_i;
    // Edges are ignored until prev has seen real synchronised data after reset.
    assign primed = (prime_cnt == CNT_W'(PRIME_MAX));
    assign clr    = (wr_en && sel == ADDR_STATUS) ? wdata_i : '0;

    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (irq_type_e'(type_q[i]) == TYPE_LEVEL) begin
                ev[i] = (sync_p0[i] == pol_q[i]);
            end else begin
                ev[i] = primed & edge_hit(sync_p0[i], prev_p1[i], pol_q[i], both_q[i]);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            ADDR_IN:     rd_val = sync_p0;
            ADDR_IE:     rd_val = ie_q;
            ADDR_TYPE:   rd_val = type_q;
            ADDR_POL:    rd_val = pol_q;
            ADDR_BOTH:   rd_val = both_q;
            ADDR_STATUS: rd_val = status_q;
            default:     rd_val = '0;
        endcase
    end

    // Register stage: edge history, config, sticky status and the access response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_p1   <= '0;
            prime_cnt <= '0;
            ie_q      <= '0;
            type_q    <= '0;
            pol_q     <= '0;
            both_q    <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            prev_p1 <= sync_p0;
            if (!primed) begin
                prime_cnt <= prime_cnt + 1'b1;
            end
            status_q <= (status_q & ~clr) | ev;
            if (wr_en) begin
                case (sel)
                    ADDR_IE:   ie_q   <= wdata_i;
                    ADDR_TYPE: type_q <= wdata_i;
                    ADDR_POL:  pol_q  <= wdata_i;
                    ADDR_BOTH: both_q <= wdata_i;
                    default:   ;
                endcase
            end
            ack_q   <= req_i;
            rdata_q <= rd_en ? rd_val : '0;
        end
    end

    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign irq_o   = |(status_q & ie_q);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a pad-history model.
module tb_gpio_irq_ctrl;

    localparam int W    = 8;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pad_i;
    logic         req_i;
    logic         we_i;
    logic [2:0]   addr_i;
    logic [W-1:0] wdata_i;
    logic [W-1:0] rdata_o;
    logic         ack_o;
    logic         irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_irq_ctrl #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pad_i   (pad_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ack_o   (ack_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The pins seen by the core are the pad values sampled SYNC edges ago;
    // edges only count once SYNC+1 edges have passed since reset.
    logic [W-1:0] hist[$];
    int           k_edges = 0;
    logic         model_ok = 1'b0;
    logic [W-1:0] m_ie, m_type, m_pol, m_both, m_status, m_rdata;
    logic         m_ack;
    logic [W-1:0] t_s, t_p, t_ev, t_clr, t_rd;

    function automatic logic [W-1:0] samp(int idx);
        if (idx < 0 || idx >= hist.size()) return '0;
        return hist[idx];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            k_edges  <= 0;
            model_ok <= 1'b1;
            m_ie <= '0; m_type <= '0; m_pol <= '0; m_both <= '0;
            m_status <= '0; m_rdata <= '0; m_ack <= 1'b0;
        end else begin
            t_s = samp(k_edges - SYNC);
            t_p = samp(k_edges - SYNC - 1);
            for (int i = 0; i < W; i++) begin
                if (!m_type[i])                 t_ev[i] = (t_s[i] == m_pol[i]);
                else if (k_edges < SYNC + 1)    t_ev[i] = 1'b0;
                else if (m_both[i])             t_ev[i] = (t_s[i] != t_p[i]);
                else if (m_pol[i])              t_ev[i] = t_s[i] & ~t_p[i];
                else                            t_ev[i] = ~t_s[i] & t_p[i];
            end
            case (addr_i)
                3'd0: t_rd = t_s;
                3'd1: t_rd = m_ie;
                3'd2: t_rd = m_type;
                3'd3: t_rd = m_pol;
                3'd4: t_rd = m_both;
                3'd5: t_rd = m_status;
                default: t_rd = '0;
            endcase
            m_ack   <= req_i;
            m_rdata <= (req_i && !we_i) ? t_rd : '0;
            t_clr = (req_i && we_i && addr_i == 3'd5) ? wdata_i : '0;
            m_status <= (m_status & ~t_clr) | t_ev;
            if (req_i && we_i) begin
                if (addr_i == 3'd1) m_ie   <= wdata_i;
                if (addr_i == 3'd2) m_type <= wdata_i;
                if (addr_i == 3'd3) m_pol  <= wdata_i;
                if (addr_i == 3'd4) m_both <= wdata_i;
            end
            hist.push_back(pad_i);
            k_edges <= k_edges + 1;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            chk("ack", ack_o, m_ack);
            chk("rdata", rdata_o, m_rdata);
            chk("irq", irq_o, |(m_status & m_ie));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        cyc();
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [W-1:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        cyc();
        d = rdata_o;
        chk("read_ack", ack_o, 1'b1);
        req_i = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        int acks;
        rst_n = 1'b0; pad_i = 8'hFF; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
        repeat (3) cyc();
        chk("reset_ack", ack_o, 1'b0);
        chk("reset_irq", irq_o, 1'b0);
        chk("reset_rdata", rdata_o, 8'h00);
        rst_n = 1'b1;

        // Pads high through reset: edge mode configured while priming, no spurious edge
        wr(3'd2, 8'hFF);
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF);
        rd(3'd5, v); chk("primed_status", v, 8'h00);
        for (int i = 0; i < 20; i++) begin
            cyc(); chk("primed_irq", irq_o, 1'b0);
        end
        rd(3'd0, v); chk("in_read", v, 8'hFF);

        // Rising edge on pin 0: two-edge latency, W1C clear, no re-set
        wr(3'd4, 8'h00); wr(3'd2, 8'h01); wr(3'd3, 8'h01); wr(3'd1, 8'h01);
        pad_i = 8'hFE;
        repeat (4) cyc();
        wr(3'd5, 8'hFF);
        chk("rise_pre", irq_o, 1'b0);
        pad_i = 8'hFF;
        cyc(); chk("rise_k", irq_o, 1'b0);
        cyc(); chk("rise_k1", irq_o, 1'b0);
        cyc(); chk("rise_k2", irq_o, 1'b1);
        rd(3'd5, v); chk("rise_status", v, 8'h01);
        wr(3'd5, 8'h01); chk("rise_clr_irq", irq_o, 1'b0);
        repeat (5) cyc();
        rd(3'd5, v); chk("rise_no_reset", v, 8'h00);

        // Level high on pin 1: clear cannot stick while active
        wr(3'd2, 8'h00); wr(3'd3, 8'h02); wr(3'd1, 8'h02);
        wr(3'd5, 8'hFF);
        rd(3'd5, v); chk("level_reappear", v, 8'h02);
        chk("level_irq", irq_o, 1'b1);
        pad_i = 8'hFD;
        repeat (3) cyc();
        wr(3'd5, 8'hFF);
        rd(3'd5, v); chk("level_gone", v, 8'h00);
        chk("level_irq_off", irq_o, 1'b0);

        // Any-edge on upper nibble, sticky, gated by IE
        wr(3'd1, 8'h00); wr(3'd2, 8'hF0); wr(3'd4, 8'hF0); wr(3'd3, 8'h0F);
        pad_i = 8'h00;
        repeat (4) cyc();
        wr(3'd5, 8'hFF);
        rd(3'd5, v); chk("both_clean", v, 8'h00);
        pad_i = 8'hA0; repeat (3) cyc();
        pad_i = 8'h00; repeat (4) cyc();
        rd(3'd5, v); chk("both_status", v, 8'hA0);
        chk("both_irq_masked", irq_o, 1'b0);
        repeat (3) cyc();
        rd(3'd5, v); chk("both_sticky", v, 8'hA0);
        wr(3'd1, 8'h80); chk("both_irq_en", irq_o, 1'b1);

        // Falling edge on pin 2 coincides with a STATUS clear: set wins
        wr(3'd4, 8'h00); wr(3'd2, 8'h04); wr(3'd3, 8'hFB);
        pad_i = 8'h04;
        repeat (4) cyc();
        wr(3'd5, 8'hFF);
        rd(3'd5, v); chk("fall_clean", v, 8'h00);
        pad_i = 8'h00;
        cyc(); cyc();
        wr(3'd5, 8'h04);
        rd(3'd5, v); chk("set_wins", v, 8'h04);

        // Unmapped addresses and back-to-back reads
        rd(3'd6, v); chk("addr6_rdata", v, 8'h00);
        cyc(); chk("addr6_ack_single", ack_o, 1'b0);
        wr(3'd7, 8'h55);
        chk("addr7_ack", ack_o, 1'b1);
        chk("addr7_rdata", rdata_o, 8'h00);
        cyc(); chk("addr7_ack_single", ack_o, 1'b0);
        rd(3'd1, v); chk("ie_kept", v, 8'h80);
        rd(3'd2, v); chk("type_kept", v, 8'h04);
        rd(3'd3, v); chk("pol_kept", v, 8'hFB);
        rd(3'd4, v); chk("both_kept", v, 8'h00);
        acks = 0;
        req_i = 1'b1; we_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_i = 3'(i + 1);
            cyc();
            acks += int'(ack_o);
        end
        req_i = 1'b0;
        cyc();
        acks += int'(ack_o);
        chk("b2b_acks", acks, 4);

        // Randomized traffic with one mid-run reset
        for (int n = 0; n < 3000; n++) begin
            rst_n   = !(n >= 1500 && n < 1503);
            req_i   = $urandom_range(0, 1);
            we_i    = $urandom_range(0, 1);
            addr_i  = 3'($urandom_range(0, 7));
            wdata_i = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pad_i = 8'($urandom);
            cyc();
        end
        rst_n = 1'b1; req_i = 1'b0; we_i = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
